pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage RISC-V pipeline. Combines the load-use hazard flag,
//  EX-stage branch redirect and the data-memory ready handshake into per-stage enable/flush controls.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 49 ++++
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 36 +++
 rtl/pipeline_hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM state encoding and
// the per-stage control bundle with its canned decode patterns.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_e;

    // Field order fixes the bundle bit positions, MSB first.
    typedef struct packed {
        logic pc_en;
        logic pc_redirect;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic memwb_en;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{
        pc_en: 1'b0, pc_redirect: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1,
        idex_en: 1'b0, idex_flush: 1'b1, exmem_en: 1'b0, memwb_en: 1'b0
    };

    localparam ctrl_t CTRL_HOLD = '{
        pc_en: 1'b0, pc_redirect: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
        idex_en: 1'b0, idex_flush: 1'b0, exmem_en: 1'b0, memwb_en: 1'b0
    };

    localparam ctrl_t CTRL_REDIRECT = '{
        pc_en: 1'b1, pc_redirect: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1,
        idex_en: 1'b1, idex_flush: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1
    };

    // The ID/EX register is enabled but the flush makes it take the bubble.
    localparam ctrl_t CTRL_LOAD_USE = '{
        pc_en: 1'b0, pc_redirect: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
        idex_en: 1'b1, idex_flush: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1
    };

    localparam ctrl_t CTRL_NORMAL = '{
        pc_en: 1'b1, pc_redirect: 1'b0, ifid_en: 1'b1, ifid_flush: 1'b0,
        idex_en: 1'b1, idex_flush: 1'b0, exmem_en: 1'b1, memwb_en: 1'b1
    };

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: reset is synchronous here, so rst_n is only sampled inside the clocked block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: priority decode of memory
// freeze, branch redirect and load-use hazard, plus a memory-timeout FSM.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_hazard,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             cnt_clr,
    output logic             pc_en,
    output logic             pc_redirect,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_e            state_q;
    state_e            state_d;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_d;
    logic              mem_err_q;
    logic              mem_err_d;

    ctrl_t             ctrl;
    logic              freeze;
    logic              do_redirect;
    logic              do_load_use;

    assign freeze = dmem_req & ~dmem_ready & (state_q != ST_ERR);

    // Mealy output decode: ERR > freeze > redirect > load-use > normal.
    always_comb begin
        ctrl        = CTRL_NORMAL;
        do_redirect = 1'b0;
        do_load_use = 1'b0;
        if (!rst_n) begin
            ctrl = CTRL_RESET;
        end else if (state_q == ST_ERR) begin
            ctrl = CTRL_HOLD;
        end else if (freeze) begin
            ctrl = CTRL_HOLD;
        end else if (branch_taken) begin
            ctrl        = CTRL_REDIRECT;
            do_redirect = 1'b1;
        end else if (load_hazard) begin
            ctrl        = CTRL_LOAD_USE;
            do_load_use = 1'b1;
        end
    end

    // A dropped request or a ready both end the wait; the stage advances the same cycle.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        case (state_q)
            ST_RUN: begin
                if (freeze) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WAIT_ONE;
                end
            end
            ST_MEM_WAIT: begin
                if (freeze) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d   = ST_ERR;
                        mem_err_d = 1'b1;
                    end
                end else begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (do_load_use),
        .q     (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (do_redirect),
        .q     (flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_freeze_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (freeze),
        .q     (freeze_cnt)
    );

    assign pc_en       = ctrl.pc_en;
    assign pc_redirect = ctrl.pc_redirect;
    assign ifid_en     = ctrl.ifid_en;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_en     = ctrl.idex_en;
    assign idex_flush  = ctrl.idex_flush;
    assign exmem_en    = ctrl.exmem_en;
    assign memwb_en    = ctrl.memwb_en;
    assign mem_err     = mem_err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: per-cycle expectations go through a
// scoreboard queue, plus explicit counter and error checks after key edges.
module tb_pipeline_hazard_ctrl;

    localparam int TO   = 8;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_hazard;
    logic          branch_taken;
    logic          dmem_req;
    logic          dmem_ready;
    logic          cnt_clr;
    logic          pc_en;
    logic          pc_redirect;
    logic          ifid_en;
    logic          ifid_flush;
    logic          idex_en;
    logic          idex_flush;
    logic          exmem_en;
    logic          memwb_en;
    logic          mem_err;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;
    logic [CW-1:0] freeze_cnt;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_hazard  (load_hazard),
        .branch_taken (branch_taken),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .cnt_clr      (cnt_clr),
        .pc_en        (pc_en),
        .pc_redirect  (pc_redirect),
        .ifid_en      (ifid_en),
        .ifid_flush   (ifid_flush),
        .idex_en      (idex_en),
        .idex_flush   (idex_flush),
        .exmem_en     (exmem_en),
        .memwb_en     (memwb_en),
        .mem_err      (mem_err),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
        .freeze_cnt   (freeze_cnt)
    );

    always #5 clk = ~clk;

    // Expected control order: pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en
    typedef struct {
        string      tag;
        logic [7:0] ctrl;
        logic       err;
        int         s;
        int         f;
        int         z;
    } exp_t;

    exp_t sb_q[$];

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: 0=RUN, 1=MEM_WAIT, 2=ERR
    int m_state = 0;
    int m_wait  = 0;
    bit m_err   = 1'b0;
    int m_s     = 0;
    int m_f     = 0;
    int m_z     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input bit rn, input bit lh, input bit bt,
                        input bit rq, input bit rd, input bit clr);
        exp_t e;
        exp_t got;
        bit   frz;
        @(negedge clk);
        rst_n        = rn;
        load_hazard  = lh;
        branch_taken = bt;
        dmem_req     = rq;
        dmem_ready   = rd;
        cnt_clr      = clr;

        frz   = rq && !rd && (m_state != 2);
        e.tag = tag;
        if (!rn)                e.ctrl = 8'b0001_0100;
        else if (m_state == 2)  e.ctrl = 8'b0000_0000;
        else if (frz)           e.ctrl = 8'b0000_0000;
        else if (bt)            e.ctrl = 8'b1111_1111;
        else if (lh)            e.ctrl = 8'b0000_1111;
        else                    e.ctrl = 8'b1010_1011;
        e.err = m_err;
        e.s   = m_s;
        e.f   = m_f;
        e.z   = m_z;
        sb_q.push_back(e);

        #2;
        got = sb_q.pop_front();
        chk({got.tag, ".ctrl"}, {24'd0, pc_en, pc_redirect, ifid_en, ifid_flush,
                                 idex_en, idex_flush, exmem_en, memwb_en}, {24'd0, got.ctrl});
        chk({got.tag, ".mem_err"}, {31'd0, mem_err}, {31'd0, got.err});
        chk({got.tag, ".stall_cnt"}, 32'(stall_cnt), 32'(got.s));
        chk({got.tag, ".flush_cnt"}, 32'(flush_cnt), 32'(got.f));
        chk({got.tag, ".freeze_cnt"}, 32'(freeze_cnt), 32'(got.z));

        // Advance the model across the coming rising edge.
        if (!rn) begin
            m_state = 0; m_wait = 0; m_err = 1'b0;
            m_s = 0; m_f = 0; m_z = 0;
        end else begin
            bit redir;
            bit lu;
            redir = (m_state != 2) && !frz && bt;
            lu    = (m_state != 2) && !frz && !bt && lh;
            if (clr) begin
                m_s = 0; m_f = 0; m_z = 0;
            end else begin
                if (lu    && m_s < MAXC) m_s++;
                if (redir && m_f < MAXC) m_f++;
                if (frz   && m_z < MAXC) m_z++;
            end
            if (m_state == 0) begin
                if (frz) begin m_state = 1; m_wait = 1; end
            end else if (m_state == 1) begin
                if (frz) begin
                    if (m_wait == TO - 1) begin m_state = 2; m_err = 1'b1; end
                    m_wait++;
                end else begin
                    m_state = 0; m_wait = 0;
                end
            end
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; load_hazard = 1'b0; branch_taken = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0; cnt_clr = 1'b0;

        // Reset held, then released with quiet inputs
        for (int i = 0; i < 3; i++) step("reset", 0, 0, 0, 0, 0, 0);
        step("idle", 1, 0, 0, 0, 0, 0);

        // Single load-use bubble
        step("load_use", 1, 1, 0, 0, 0, 0);
        step("after_lu", 1, 0, 0, 0, 0, 0);
        after_edge();
        chk("stall_cnt_one", 32'(stall_cnt), 32'd1);

        // Redirect discards a simultaneous load-use
        step("br_and_lu", 1, 1, 1, 0, 0, 0);
        step("after_br", 1, 0, 0, 0, 0, 0);
        after_edge();
        chk("flush_cnt_one", 32'(flush_cnt), 32'd1);
        chk("stall_cnt_kept", 32'(stall_cnt), 32'd1);

        // Five frozen cycles (pending branch/hazard ignored), resume on ready
        for (int i = 0; i < 5; i++) step("freeze", 1, i == 2, i == 3, 1, 0, 0);
        step("mem_ready", 1, 0, 0, 1, 1, 0);
        step("after_mem", 1, 0, 0, 0, 0, 0);
        after_edge();
        chk("freeze_cnt_five", 32'(freeze_cnt), 32'd5);
        chk("no_err_short_wait", {31'd0, mem_err}, 32'd0);

        // Request dropped mid-wait counts as completion; redirect goes through
        for (int i = 0; i < 2; i++) step("freeze_drop", 1, 0, 0, 1, 0, 0);
        step("req_drop_br", 1, 0, 1, 0, 0, 0);

        // Timeout: eight frozen cycles enter ERR, which is sticky
        for (int i = 0; i < TO; i++) step("timeout_wait", 1, 0, 0, 1, 0, 0);
        step("err_br", 1, 1, 1, 0, 0, 0);
        step("err_frz", 1, 0, 0, 1, 0, 0);
        after_edge();
        chk("mem_err_sticky", {31'd0, mem_err}, 32'd1);
        chk("freeze_cnt_sat", 32'(freeze_cnt), 32'(MAXC));
        step("err_clear_rst", 0, 0, 0, 0, 0, 0);
        step("after_err_rst", 1, 0, 0, 0, 0, 0);

        // Reset in the middle of a memory wait
        for (int i = 0; i < 3; i++) step("freeze_pre_rst", 1, 0, 0, 1, 0, 0);
        step("rst_mid_wait", 0, 0, 0, 1, 0, 0);
        step("after_wait_rst", 1, 0, 0, 0, 0, 0);
        after_edge();
        chk("freeze_cnt_rst", 32'(freeze_cnt), 32'd0);

        // Counter saturation, then clear beats increment
        for (int i = 0; i < 20; i++) step("lu_burst", 1, 1, 0, 0, 0, 0);
        after_edge();
        chk("stall_cnt_sat", 32'(stall_cnt), 32'(MAXC));
        step("clr_with_lu", 1, 1, 0, 0, 0, 1);
        after_edge();
        chk("stall_cnt_cleared", 32'(stall_cnt), 32'd0);
        step("final", 1, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
